// File: rtl/dmem_responder.sv
// dmem_responder: M-stage data-memory responder with a word RAM and an MMIO register page.
// Optional misaligned-store trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int          MEM_WORDS = 64,
  parameter logic [23:0] MMIO_PAGE = 24'h0000FF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite_M,
  input  logic [31:0] DataAdr_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic [7:0]  led,
  output logic        done,
  output logic        pass,
  output logic        misalign
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [5:0] OFF_CYCLE_LO  = 6'h00;
  localparam logic [5:0] OFF_CYCLE_HI  = 6'h01;
  localparam logic [5:0] OFF_LED       = 6'h02;
  localparam logic [5:0] OFF_TOHOST    = 6'h03;
  localparam logic [5:0] OFF_STORE_CNT = 6'h04;

  logic [31:0]      mem_r [MEM_WORDS];
  logic [63:0]      cycle_r;
  logic [31:0]      store_cnt_r;
  logic [7:0]       led_r;
  logic             done_r;
  logic             pass_r;

  logic [IDX_W-1:0] idx_s;
  logic             mmio_sel_s;
  logic [5:0]       off_s;
  logic             store_ok_s;
  logic             ram_we_s;
  logic             led_we_s;
  logic             tohost_we_s;
  logic [31:0]      rdata_s;

  assign idx_s      = DataAdr_M[IDX_W+1:2];
  assign mmio_sel_s = (DataAdr_M[31:8] == MMIO_PAGE);
  assign off_s      = DataAdr_M[7:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_r;

  // A misaligned store is dropped entirely and latches the sticky trap flag
  assign store_ok_s = MemWrite_M & (DataAdr_M[1:0] == 2'b00);

  // Sticky misalignment flag, cleared only by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_r <= 1'b0;
    end else if (MemWrite_M && (DataAdr_M[1:0] != 2'b00)) begin
      misalign_r <= 1'b1;
    end
  end

  assign misalign = misalign_r;
`else
  logic unused_addr_lo_s;

  assign store_ok_s       = MemWrite_M;
  assign misalign         = 1'b0;
  assign unused_addr_lo_s = ^DataAdr_M[1:0];
`endif

  assign ram_we_s    = store_ok_s & ~mmio_sel_s;
  assign led_we_s    = store_ok_s & mmio_sel_s & (off_s == OFF_LED);
  assign tohost_we_s = store_ok_s & mmio_sel_s & (off_s == OFF_TOHOST);

  // RAM array: no reset, contents undefined until first store
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_r[idx_s] <= WriteData_M;
    end
  end

  // MMIO registers; the cycle counter stops once the test has reported
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r     <= 64'd0;
      store_cnt_r <= 32'd0;
      led_r       <= 8'd0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      if (!done_r) begin
        cycle_r <= cycle_r + 64'd1;
      end
      if (ram_we_s) begin
        store_cnt_r <= store_cnt_r + 32'd1;
      end
      if (led_we_s) begin
        led_r <= WriteData_M[7:0];
      end
      if (tohost_we_s && !done_r) begin
        done_r <= 1'b1;
        pass_r <= (WriteData_M == 32'h0000_0001);
      end
    end
  end

  // Combinational load path; a same-cycle store is seen only from the next cycle
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (mmio_sel_s) begin
      case (off_s)
        OFF_CYCLE_LO:  rdata_s = cycle_r[31:0];
        OFF_CYCLE_HI:  rdata_s = cycle_r[63:32];
        OFF_LED:       rdata_s = {24'h00_0000, led_r};
        OFF_STORE_CNT: rdata_s = store_cnt_r;
        default:       rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = mem_r[idx_s];
    end
  end

  assign ReadData_M = rdata_s;
  assign led        = led_r;
  assign done       = done_r;
  assign pass       = pass_r;

endmodule
